// File: rtl/lab2_proc_iter_div_unit.sv
// lab2_proc_iter_div_unit
//   Iterative 32-bit divide/remainder unit (DIV, DIVU, REM, REMU) for the
//   lab2 processor X stage. It uses restoring shift-subtract division and
//   produces one quotient bit per cycle. A request that fires in cycle t
//   gives a response in cycle t+33. Only one operation is in flight at a time.
//
// Ports
//   clk       in   clock, rising-edge
//   reset_n   in   asynchronous active-low reset
//   req_val   in   request valid
//   req_rdy   out  unit idle and able to accept a request
//   req_fn    in   [1:0] 0=DIV 1=DIVU 2=REM 3=REMU
//   req_a     in   [31:0] dividend
//   req_b     in   [31:0] divisor
//   resp_val  out  result valid (held until resp_rdy)
//   resp_rdy  in   consumer accepts result
//   resp_msg  out  [31:0] quotient or remainder
`timescale 1ns/1ps
module lab2_proc_iter_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [1:0]  req_fn,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_msg
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {
    FN_DIV  = 2'd0,
    FN_DIVU = 2'd1,
    FN_REM  = 2'd2,
    FN_REMU = 2'd3
  } fn_t;

  state_t      state, state_nxt;
  fn_t         fn;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic [4:0]  cnt;
  logic        quo_neg;
  logic        rem_neg;
  logic        b_zero;

  logic        req_fire;
  logic        resp_fire;

  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;

  // ---------------------------------------------------------------------
  // Operand preparation (IDLE, on request fire)
  // ---------------------------------------------------------------------
  logic        in_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    in_signed = (req_fn == FN_DIV) || (req_fn == FN_REM);
    a_neg     = in_signed && req_a[31];
    b_neg     = in_signed && req_b[31];
    a_mag     = a_neg ? -req_a : req_a;
    b_mag     = b_neg ? -req_b : req_b;
  end

  // ---------------------------------------------------------------------
  // One restoring iteration
  // The bit shifted out of the remainder is kept as a 33rd bit. Without it,
  // divisors with bit 31 set would lose the carry. Any result that is kept
  // is below the divisor, so it always fits back into 32 bits.
  // ---------------------------------------------------------------------
  logic [32:0] rem_sh;
  logic        take;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  always_comb begin
    rem_sh  = {rem, quo[31]};
    take    = rem_sh >= {1'b0, divisor};
    rem_nxt = take ? 32'(rem_sh - {1'b0, divisor}) : rem_sh[31:0];
    quo_nxt = {quo[30:0], take};
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_fire) state_nxt = CALC;
      CALC: if (cnt == 5'd31) state_nxt = DONE;
      DONE: if (resp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    unique case (state)
      IDLE:    req_rdy  = 1'b1;
      CALC:    ;
      DONE:    resp_val = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fn      <= FN_DIV;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      cnt     <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      b_zero  <= 1'b0;
    end else if (state == IDLE) begin
      if (req_fire) begin
        fn      <= fn_t'(req_fn);
        rem     <= '0;
        quo     <= a_mag;
        divisor <= b_mag;
        cnt     <= '0;
        quo_neg <= a_neg ^ b_neg;
        rem_neg <= a_neg;
        b_zero  <= (req_b == '0);
      end
    end else if (state == CALC) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      cnt <= cnt + 5'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Sign fix-up
  // A zero divisor leaves quo = all ones and rem = |a|. Suppressing only the
  // quotient negation then gives the required divide-by-zero results.
  // Signed overflow needs no special case: |0x80000000| / 1 yields
  // 0x80000000 with remainder 0.
  // ---------------------------------------------------------------------
  always_comb begin
    resp_msg = '0;
    unique case (fn)
      FN_DIV:  resp_msg = (quo_neg && !b_zero) ? -quo : quo;
      FN_DIVU: resp_msg = quo;
      FN_REM:  resp_msg = rem_neg ? -rem : rem;
      FN_REMU: resp_msg = rem;
      default: resp_msg = '0;
    endcase
  end

endmodule

// File: tb/tb_lab2_proc_iter_div_unit.sv
`timescale 1ns/1ps
module tb_lab2_proc_iter_div_unit;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        req_val  = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_fn   = '0;
  logic [31:0] req_a    = '0;
  logic [31:0] req_b    = '0;
  logic        resp_val;
  logic        resp_rdy = 1'b0;
  logic [31:0] resp_msg;

  lab2_proc_iter_div_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_fn   (req_fn),
    .req_a    (req_a),
    .req_b    (req_b),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          id;
  } sb_t;

  sb_t         scb[$];
  vec_t        vecs[16];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h need=%h", name, got, exp);
    end
  endfunction

  // Independent reference model for the RISC-V M divide ops
  function automatic logic [31:0] model(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (fn)
      2'd0: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      2'd1: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'd2: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: scoreboard pop, latency, hold-while-stalled
  initial begin
    int unsigned fire_cyc;
    bit          waiting;
    bit          prev_val;
    bit          prev_fire;
    logic [31:0] prev_msg;
    sb_t         item;
    waiting   = 0;
    prev_val  = 0;
    prev_fire = 0;
    prev_msg  = '0;
    fire_cyc  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        waiting  = 0;
        prev_val = 0;
      end else begin
        if (req_val && req_rdy) begin
          fire_cyc = cyc;
          waiting  = 1;
        end
        if (prev_val && !prev_fire) begin
          chk("resp_val_hold", {31'd0, resp_val}, 32'd1);
          chk("resp_msg_hold", resp_msg, prev_msg);
        end
        if (resp_val && !prev_val) begin
          if (!waiting) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp_val got=1 need=0");
          end else begin
            chk("latency", 32'(cyc - fire_cyc), 32'd33);
            waiting = 0;
          end
          chk("req_rdy_in_done", {31'd0, req_rdy}, 32'd0);
        end
        if (resp_val && resp_rdy) begin
          if (scb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_without_req got=%h need=none", resp_msg);
          end else begin
            item = scb.pop_front();
            total++;
            if (resp_msg !== item.exp) begin
              bad++;
              $display("FAIL result id=%0d got=%h need=%h", item.id, resp_msg, item.exp);
            end
          end
        end
        prev_val  = resp_val;
        prev_msg  = resp_msg;
        prev_fire = resp_val && resp_rdy;
      end
    end
  end

  task automatic issue(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int id);
    bit done;
    done    = 0;
    req_fn  = fn;
    req_a   = a;
    req_b   = b;
    req_val = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (req_rdy) begin
        scb.push_back('{exp: exp, id: id});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    // Scramble the request bus after fire; the unit must ignore it.
    req_val = 1'b0;
    req_fn  = 2'($urandom);
    req_a   = $urandom;
    req_b   = $urandom;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout id=%0d got req_rdy=0 need=1", id);
    end
  endtask

  task automatic wait_idle(input int id);
    bit ok;
    ok       = 0;
    resp_rdy = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (scb.size() == 0 && req_rdy && !resp_val) ok = 1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain_timeout id=%0d got pending=%0d need=0", id, scb.size());
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    bit          seen;
    bit          fired;
    int          issued;
    int          gap;

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    vecs[3]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[4]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[5]  = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[6]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[7]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[8]  = '{2'd0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{2'd3, 32'd5,          32'd0,          32'd5};
    vecs[10] = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    vecs[11] = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[12] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[13] = '{2'd1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1};
    vecs[14] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1};
    vecs[15] = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_rdy",  {31'd0, req_rdy},  32'd1);
    chk("reset_resp_val", {31'd0, resp_val}, 32'd0);
    chk("reset_resp_msg", resp_msg,          32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp, i);
      wait_idle(i);
    end

    // Backpressure: hold resp_rdy low for 10 cycles once resp_val rises
    resp_rdy = 1'b0;
    issue(2'd1, 32'd1000, 32'd10, 32'd100, 100);
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (resp_val) got = 1;
    end
    chk("bp_resp_val_seen", {31'd0, got}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_resp_val", {31'd0, resp_val}, 32'd1);
      chk("bp_req_rdy",  {31'd0, req_rdy},  32'd0);
      chk("bp_resp_msg", resp_msg,          32'd100);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_fn   = 2'd1;
    req_a    = 32'd9;
    req_b    = 32'd3;
    req_val  = 1'b1;
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_req_rdy_after_fire", {31'd0, req_rdy}, 32'd1);
    if (req_val && req_rdy) scb.push_back('{exp: 32'd3, id: 101});
    @(posedge clk);
    #1;
    req_val = 1'b0;
    wait_idle(101);

    // Reset in CALC at iteration 15
    issue(2'd1, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 200);
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_req_rdy",  {31'd0, req_rdy},  32'd1);
    chk("midreset_resp_val", {31'd0, resp_val}, 32'd0);
    chk("midreset_resp_msg", resp_msg,          32'd0);
    scb.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_val) seen = 1;
    end
    chk("no_stale_resp", {31'd0, seen}, 32'd0);
    @(posedge clk);
    #1;
    issue(2'd1, 32'd9, 32'd3, 32'd3, 201);
    wait_idle(201);

    // Random traffic with request gaps and response backpressure
    issued = 0;
    gap    = 0;
    fired  = 0;
    for (int c = 0; c < 60000 && issued < 1000; c++) begin
      @(posedge clk);
      #1;
      resp_rdy = ($urandom_range(0, 3) != 0);
      if (fired) begin
        req_val = 1'b0;
        req_a   = $urandom;
        req_b   = $urandom;
        fired   = 0;
        gap     = $urandom_range(0, 4);
      end else if (!req_val) begin
        if (gap > 0) begin
          gap--;
        end else begin
          req_fn = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 4))
            0:       req_a = 32'd0;
            1:       req_a = 32'h8000_0000;
            2:       req_a = $urandom_range(0, 100);
            default: req_a = $urandom;
          endcase
          case ($urandom_range(0, 5))
            0:       req_b = 32'd0;
            1:       req_b = 32'd1;
            2:       req_b = 32'hFFFF_FFFF;
            3:       req_b = $urandom_range(1, 20);
            default: req_b = $urandom;
          endcase
          req_val = 1'b1;
        end
      end
      @(negedge clk);
      if (req_val && req_rdy) begin
        scb.push_back('{exp: model(req_fn, req_a, req_b), id: 1000 + issued});
        issued++;
        fired = 1;
      end
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
    chk("random_issued", 32'(issued), 32'd1000);
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
